// File: rtl/ccd_capture_roi_if.sv
// ccd_capture_roi_if
// Bundles the sensor-side inputs, the runtime control and ROI fields, and the
// cropped pixel stream of the D5M capture stage. The sensor/control side uses
// the master modport and the capture block uses the slave modport.
interface ccd_capture_roi_if #(
  parameter int DATA_W = 12,
  parameter int CNT_W  = 16,
  parameter int FCNT_W = 32
);
  logic [DATA_W-1:0] iDATA;
  logic              iFVAL;
  logic              iLVAL;
  logic              iSTART;
  logic              iEND;
  logic [CNT_W-1:0]  iWIN_X0;
  logic [CNT_W-1:0]  iWIN_Y0;
  logic [CNT_W-1:0]  iWIN_W;
  logic [CNT_W-1:0]  iWIN_H;
  logic [DATA_W-1:0] oDATA;
  logic              oDVAL;
  logic [CNT_W-1:0]  oX_Cont;
  logic [CNT_W-1:0]  oY_Cont;
  logic [FCNT_W-1:0] oFrame_Cont;
  logic              oSOF;
  logic              oEOF;
  logic              oBUSY;

  modport master (
    output iDATA, iFVAL, iLVAL, iSTART, iEND, iWIN_X0, iWIN_Y0, iWIN_W, iWIN_H,
    input  oDATA, oDVAL, oX_Cont, oY_Cont, oFrame_Cont, oSOF, oEOF, oBUSY
  );

  modport slave (
    input  iDATA, iFVAL, iLVAL, iSTART, iEND, iWIN_X0, iWIN_Y0, iWIN_W, iWIN_H,
    output oDATA, oDVAL, oX_Cont, oY_Cont, oFrame_Cont, oSOF, oEOF, oBUSY
  );
endinterface

// File: rtl/ccd_capture_roi.sv
// ccd_capture_roi
// D5M frame-capture stage: registers the raw FVAL/LVAL-framed pixel stream,
// tracks raw column/row, crops to a per-frame shadowed ROI and emits a
// DVAL-qualified stream with window-relative coordinates, SOF/EOF pulses and
// a completed-frame counter. Capture is armed and stopped frame-synchronously.
// LVAL is expected to rise at least one cycle after FVAL, as the D5M does.
module ccd_capture_roi #(
  parameter int DATA_W = 12,
  parameter int CNT_W  = 16,
  parameter int FCNT_W = 32
) (
  input logic               iCLK,
  input logic               iRST_N,
  ccd_capture_roi_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ARMED    = 2'd1,
    ST_CAPTURE  = 2'd2,
    ST_STOPPING = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [FCNT_W-1:0] FCNT_ONE = {{(FCNT_W-1){1'b0}}, 1'b1};

  // input registers and edge-detect second stage
  logic [DATA_W-1:0] d_r;
  logic              fval_r;
  logic              lval_r;
  logic              fval_d_r;
  logic              lval_d_r;
  // prime_r[1] is set once fval_d_r holds a genuine sensor sample, so a frame
  // already in progress when reset releases is not mistaken for a new one
  logic [1:0]        prime_r;

  logic [CNT_W-1:0]  x_r;
  logic [CNT_W-1:0]  y_r;
  logic [CNT_W-1:0]  x0_r;
  logic [CNT_W-1:0]  y0_r;
  logic [CNT_W-1:0]  w_r;
  logic [CNT_W-1:0]  h_r;

  state_t            state_r;
  state_t            state_s;

  logic              acc_r;
  logic [DATA_W-1:0] pix_r;
  logic [CNT_W-1:0]  xo_r;
  logic [CNT_W-1:0]  yo_r;

  logic [DATA_W-1:0] odata_r;
  logic              odval_r;
  logic [CNT_W-1:0]  ox_r;
  logic [CNT_W-1:0]  oy_r;
  logic [FCNT_W-1:0] frame_r;
  logic              sof_r;
  logic              eof_r;
  logic              busy_r;

  logic              f_rise_s;
  logic              f_fall_s;
  logic              l_fall_s;
  logic              cap_s;
  logic [CNT_W:0]    x_end_s;
  logic [CNT_W:0]    y_end_s;
  logic              in_x_s;
  logic              in_y_s;
  logic              acc_s;
  logic              sof_s;
  logic              eof_s;

  assign f_rise_s = fval_r & ~fval_d_r & prime_r[1];
  assign f_fall_s = ~fval_r & fval_d_r & prime_r[1];
  assign l_fall_s = ~lval_r & lval_d_r;
  assign cap_s    = (state_r == ST_CAPTURE) || (state_r == ST_STOPPING);

  // window ends are one bit wider so X0+W / Y0+H can never wrap
  assign x_end_s  = {1'b0, x0_r} + {1'b0, w_r};
  assign y_end_s  = {1'b0, y0_r} + {1'b0, h_r};
  assign in_x_s   = (x_r >= x0_r) && ({1'b0, x_r} < x_end_s);
  assign in_y_s   = (y_r >= y0_r) && ({1'b0, y_r} < y_end_s);
  assign acc_s    = cap_s & fval_r & lval_r & in_x_s & in_y_s;

  // register raw sensor inputs and keep a delayed copy for edge detection
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      d_r      <= {DATA_W{1'b0}};
      fval_r   <= 1'b0;
      lval_r   <= 1'b0;
      fval_d_r <= 1'b0;
      lval_d_r <= 1'b0;
      prime_r  <= 2'b00;
    end else begin
      d_r      <= bus.iDATA;
      fval_r   <= bus.iFVAL;
      lval_r   <= bus.iLVAL;
      fval_d_r <= fval_r;
      lval_d_r <= lval_r;
      prime_r  <= {prime_r[0], 1'b1};
    end
  end

  // saturating raw column/row counters; LVAL outside FVAL does not advance them
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      x_r <= {CNT_W{1'b0}};
      y_r <= {CNT_W{1'b0}};
    end else begin
      if (!lval_r) begin
        x_r <= {CNT_W{1'b0}};
      end else if (fval_r && (x_r != CNT_MAX)) begin
        x_r <= x_r + CNT_ONE;
      end else begin
        x_r <= x_r;
      end
      if (f_rise_s) begin
        y_r <= {CNT_W{1'b0}};
      end else if (l_fall_s && fval_r && (y_r != CNT_MAX)) begin
        y_r <= y_r + CNT_ONE;
      end else begin
        y_r <= y_r;
      end
    end
  end

  // shadow the ROI at each frame start so mid-frame edits wait for the next frame
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      x0_r <= {CNT_W{1'b0}};
      y0_r <= {CNT_W{1'b0}};
      w_r  <= {CNT_W{1'b0}};
      h_r  <= {CNT_W{1'b0}};
    end else if (f_rise_s) begin
      x0_r <= bus.iWIN_X0;
      y0_r <= bus.iWIN_Y0;
      w_r  <= bus.iWIN_W;
      h_r  <= bus.iWIN_H;
    end else begin
      x0_r <= x0_r;
      y0_r <= y0_r;
      w_r  <= w_r;
      h_r  <= h_r;
    end
  end

  // capture control state register
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // next-state logic plus SOF/EOF decode; iEND always takes priority over iSTART
  always_comb begin
    state_s = state_r;
    sof_s   = 1'b0;
    eof_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.iSTART && !bus.iEND) begin
          state_s = ST_ARMED;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ARMED: begin
        if (bus.iEND) begin
          state_s = ST_IDLE;
        end else if (f_rise_s) begin
          state_s = ST_CAPTURE;
          sof_s   = 1'b1;
        end else begin
          state_s = ST_ARMED;
        end
      end
      ST_CAPTURE: begin
        sof_s = f_rise_s;
        eof_s = f_fall_s;
        if (bus.iEND) begin
          // a frame still in flight is finished in STOPPING; otherwise stop now
          if (fval_r) begin
            state_s = ST_STOPPING;
          end else begin
            state_s = ST_IDLE;
          end
        end else begin
          state_s = ST_CAPTURE;
        end
      end
      ST_STOPPING: begin
        eof_s = f_fall_s;
        if (f_fall_s) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_STOPPING;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // first pipeline stage: accept decision, pixel and window-relative coordinates
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      acc_r <= 1'b0;
      pix_r <= {DATA_W{1'b0}};
      xo_r  <= {CNT_W{1'b0}};
      yo_r  <= {CNT_W{1'b0}};
    end else begin
      acc_r <= acc_s;
      if (acc_s) begin
        pix_r <= d_r;
        xo_r  <= x_r - x0_r;
        yo_r  <= y_r - y0_r;
      end else begin
        pix_r <= pix_r;
        xo_r  <= xo_r;
        yo_r  <= yo_r;
      end
    end
  end

  // output stage: data holds while not valid, frame counter steps with EOF
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      odata_r <= {DATA_W{1'b0}};
      odval_r <= 1'b0;
      ox_r    <= {CNT_W{1'b0}};
      oy_r    <= {CNT_W{1'b0}};
      frame_r <= {FCNT_W{1'b0}};
      sof_r   <= 1'b0;
      eof_r   <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      odval_r <= acc_r;
      if (acc_r) begin
        odata_r <= pix_r;
        ox_r    <= xo_r;
        oy_r    <= yo_r;
      end else begin
        odata_r <= odata_r;
        ox_r    <= ox_r;
        oy_r    <= oy_r;
      end
      if (eof_s) begin
        frame_r <= frame_r + FCNT_ONE;
      end else begin
        frame_r <= frame_r;
      end
      sof_r  <= sof_s;
      eof_r  <= eof_s;
      busy_r <= (state_s != ST_IDLE);
    end
  end

  assign bus.oDATA       = odata_r;
  assign bus.oDVAL       = odval_r;
  assign bus.oX_Cont     = ox_r;
  assign bus.oY_Cont     = oy_r;
  assign bus.oFrame_Cont = frame_r;
  assign bus.oSOF        = sof_r;
  assign bus.oEOF        = eof_r;
  assign bus.oBUSY       = busy_r;

endmodule

// File: tb/tb_ccd_capture_roi.sv
// tb_ccd_capture_roi
// Directed bench for the D5M ROI capture stage. A negedge monitor tallies the
// output stream; each scenario task drives frames and compares the tallies
// with hand-derived values.
module tb_ccd_capture_roi;

  logic iCLK;
  logic iRST_N;

  ccd_capture_roi_if #(.DATA_W(12), .CNT_W(16), .FCNT_W(32)) bus ();

  ccd_capture_roi #(.DATA_W(12), .CNT_W(16), .FCNT_W(32)) dut (
    .iCLK   (iCLK),
    .iRST_N (iRST_N),
    .bus    (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  int cyc = 0;
  int dval_cnt = 0;
  int sof_cnt = 0;
  int eof_cnt = 0;
  int mark_cnt = 0;
  int sof_m = 0;
  int eof_m = 0;
  int first_cyc = 0;
  int lat_cyc = -1;
  int lat_col = -1;
  int lat_row = -1;
  logic [15:0] first_x, first_y, last_x, last_y;
  logic [11:0] first_d, last_d;
  logic [15:0] ring_x [16];
  logic [15:0] ring_y [16];
  logic [11:0] ring_d [16];

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  // count rising edges so pixel launch and arrival can be compared
  always @(posedge iCLK) cyc = cyc + 1;

  // tally the output stream away from the active edge
  always @(negedge iCLK) begin
    if (bus.oDVAL === 1'b1) begin
      if (dval_cnt == mark_cnt) begin
        first_x   = bus.oX_Cont;
        first_y   = bus.oY_Cont;
        first_d   = bus.oDATA;
        first_cyc = cyc;
      end
      last_x = bus.oX_Cont;
      last_y = bus.oY_Cont;
      last_d = bus.oDATA;
      ring_x[dval_cnt[3:0]] = bus.oX_Cont;
      ring_y[dval_cnt[3:0]] = bus.oY_Cont;
      ring_d[dval_cnt[3:0]] = bus.oDATA;
      dval_cnt = dval_cnt + 1;
    end
    if (bus.oSOF === 1'b1) sof_cnt = sof_cnt + 1;
    if (bus.oEOF === 1'b1) eof_cnt = eof_cnt + 1;
  end

  function automatic logic [11:0] pix(input int c, input int r);
    int v;
    v = (r * 7 + c) % 4096;
    return v[11:0];
  endfunction

  task automatic drive_px(input logic f, input logic l, input logic [11:0] d);
    @(negedge iCLK);
    bus.iFVAL = f;
    bus.iLVAL = l;
    bus.iDATA = d;
  endtask

  task automatic mark();
    mark_cnt = dval_cnt;
    sof_m    = sof_cnt;
    eof_m    = eof_cnt;
  endtask

  task automatic set_win(input logic [15:0] x0, input logic [15:0] y0,
                         input logic [15:0] w, input logic [15:0] h);
    bus.iWIN_X0 = x0;
    bus.iWIN_Y0 = y0;
    bus.iWIN_W  = w;
    bus.iWIN_H  = h;
  endtask

  task automatic pulse_start();
    @(negedge iCLK);
    bus.iSTART = 1'b1;
    @(negedge iCLK);
    bus.iSTART = 1'b0;
  endtask

  // ev_kind 1: raise iEND at row ev_row; ev_kind 2: move iWIN_X0 to 10 at row ev_row
  task automatic send_frame(input int w, input int h, input int ev_row, input int ev_kind);
    drive_px(1'b1, 1'b0, 12'd0);
    drive_px(1'b1, 1'b0, 12'd0);
    for (int r = 0; r < h; r++) begin
      if (r == ev_row && ev_kind == 1) bus.iEND = 1'b1;
      if (r == ev_row && ev_kind == 2) bus.iWIN_X0 = 16'd10;
      for (int c = 0; c < w; c++) begin
        drive_px(1'b1, 1'b1, pix(c, r));
        if (c == lat_col && r == lat_row) lat_cyc = cyc + 1;
      end
      for (int g = 0; g < 3; g++) drive_px(1'b1, 1'b0, 12'd0);
    end
    for (int g = 0; g < 4; g++) drive_px(1'b0, 1'b0, 12'd0);
  endtask

  task automatic test_reset();
    iRST_N = 1'b0;
    bus.iDATA = 12'd0; bus.iFVAL = 1'b0; bus.iLVAL = 1'b0;
    bus.iSTART = 1'b0; bus.iEND = 1'b0;
    set_win(16'd0, 16'd0, 16'd0, 16'd0);
    repeat (3) @(negedge iCLK);
    checks++; if (bus.oDVAL !== 1'b0) begin errors++; $display("FAIL reset_dval: got %0d want 0", bus.oDVAL); end
    checks++; if (bus.oDATA !== 12'd0) begin errors++; $display("FAIL reset_data: got %0d want 0", bus.oDATA); end
    checks++; if (bus.oX_Cont !== 16'd0 || bus.oY_Cont !== 16'd0) begin errors++; $display("FAIL reset_xy: got %0d/%0d want 0/0", bus.oX_Cont, bus.oY_Cont); end
    checks++; if (bus.oFrame_Cont !== 32'd0) begin errors++; $display("FAIL reset_frame: got %0d want 0", bus.oFrame_Cont); end
    checks++; if (bus.oSOF !== 1'b0 || bus.oEOF !== 1'b0) begin errors++; $display("FAIL reset_sofeof: got %0d/%0d want 0/0", bus.oSOF, bus.oEOF); end
    checks++; if (bus.oBUSY !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0d want 0", bus.oBUSY); end
    iRST_N = 1'b1;
    repeat (2) @(negedge iCLK);
  endtask

  // full window over a reduced 64x48 frame
  task automatic test_full();
    set_win(16'd0, 16'd0, 16'd64, 16'd48);
    pulse_start();
    mark();
    send_frame(64, 48, -1, 0);
    checks++; if (dval_cnt - mark_cnt != 3072) begin errors++; $display("FAIL full_dval: got %0d want 3072", dval_cnt - mark_cnt); end
    checks++; if (first_x !== 16'd0 || first_y !== 16'd0) begin errors++; $display("FAIL full_first: got %0d/%0d want 0/0", first_x, first_y); end
    checks++; if (last_x !== 16'd63 || last_y !== 16'd47) begin errors++; $display("FAIL full_last: got %0d/%0d want 63/47", last_x, last_y); end
    checks++; if (last_d !== pix(63, 47)) begin errors++; $display("FAIL full_lastdata: got %0d want %0d", last_d, pix(63, 47)); end
    checks++; if (sof_cnt - sof_m != 1 || eof_cnt - eof_m != 1) begin errors++; $display("FAIL full_sofeof: got %0d/%0d want 1/1", sof_cnt - sof_m, eof_cnt - eof_m); end
    checks++; if (bus.oFrame_Cont !== 32'd1) begin errors++; $display("FAIL full_frame: got %0d want 1", bus.oFrame_Cont); end
    checks++; if (bus.oBUSY !== 1'b1) begin errors++; $display("FAIL full_busy: got %0d want 1", bus.oBUSY); end
  endtask

  // 4x2 crop at (100,50) in the following frame, capture continuing
  task automatic test_crop();
    set_win(16'd100, 16'd50, 16'd4, 16'd2);
    lat_col = 100; lat_row = 50; lat_cyc = -1;
    mark();
    send_frame(110, 53, -1, 0);
    lat_col = -1; lat_row = -1;
    checks++; if (dval_cnt - mark_cnt != 8) begin errors++; $display("FAIL crop_dval: got %0d want 8", dval_cnt - mark_cnt); end
    for (int i = 0; i < 8; i++) begin
      int k;
      k = (mark_cnt + i) % 16;
      checks++;
      if (ring_x[k] !== 16'(i % 4) || ring_y[k] !== 16'(i / 4) || ring_d[k] !== pix(100 + i % 4, 50 + i / 4)) begin
        errors++;
        $display("FAIL crop_px%0d: got x=%0d y=%0d d=%0d want x=%0d y=%0d d=%0d", i, ring_x[k], ring_y[k], ring_d[k], i % 4, i / 4, pix(100 + i % 4, 50 + i / 4));
      end
    end
    checks++; if (first_cyc - lat_cyc != 2) begin errors++; $display("FAIL crop_latency: got %0d want 2", first_cyc - lat_cyc); end
    checks++; if (sof_cnt - sof_m != 1) begin errors++; $display("FAIL crop_sof: got %0d want 1", sof_cnt - sof_m); end
    checks++; if (bus.oFrame_Cont !== 32'd2) begin errors++; $display("FAIL crop_frame: got %0d want 2", bus.oFrame_Cont); end
  endtask

  // iEND mid-frame 3: frame completes, then frame 4 is ignored
  task automatic test_stop();
    set_win(16'd0, 16'd0, 16'd8, 16'd6);
    mark();
    send_frame(8, 6, 2, 1);
    checks++; if (dval_cnt - mark_cnt != 48) begin errors++; $display("FAIL stop_dval: got %0d want 48", dval_cnt - mark_cnt); end
    checks++; if (bus.oFrame_Cont !== 32'd3) begin errors++; $display("FAIL stop_frame: got %0d want 3", bus.oFrame_Cont); end
    checks++; if (bus.oBUSY !== 1'b0) begin errors++; $display("FAIL stop_busy: got %0d want 0", bus.oBUSY); end
    bus.iEND = 1'b0;
    mark();
    send_frame(8, 6, -1, 0);
    checks++; if (dval_cnt - mark_cnt != 0 || sof_cnt - sof_m != 0) begin errors++; $display("FAIL stop_f4: got dval=%0d sof=%0d want 0/0", dval_cnt - mark_cnt, sof_cnt - sof_m); end
    checks++; if (bus.oFrame_Cont !== 32'd3) begin errors++; $display("FAIL stop_f4frame: got %0d want 3", bus.oFrame_Cont); end
  endtask

  // X0 edited 0->10 at row 5 takes effect only in the next frame
  task automatic test_roi_change();
    set_win(16'd0, 16'd0, 16'd4, 16'd8);
    pulse_start();
    mark();
    send_frame(16, 8, 5, 2);
    checks++; if (dval_cnt - mark_cnt != 32) begin errors++; $display("FAIL roi_cur_dval: got %0d want 32", dval_cnt - mark_cnt); end
    checks++; if (last_x !== 16'd3 || last_y !== 16'd7 || last_d !== pix(3, 7)) begin errors++; $display("FAIL roi_cur_last: got %0d/%0d d=%0d want 3/7 d=%0d", last_x, last_y, last_d, pix(3, 7)); end
    mark();
    send_frame(16, 8, -1, 0);
    checks++; if (first_d !== pix(10, 0) || first_x !== 16'd0) begin errors++; $display("FAIL roi_next_first: got d=%0d x=%0d want d=%0d x=0", first_d, first_x, pix(10, 0)); end
    checks++; if (dval_cnt - mark_cnt != 32) begin errors++; $display("FAIL roi_next_dval: got %0d want 32", dval_cnt - mark_cnt); end
    checks++; if (bus.oFrame_Cont !== 32'd5) begin errors++; $display("FAIL roi_frame: got %0d want 5", bus.oFrame_Cont); end
  endtask

  task automatic test_corners();
    // zero width: no pixels, frame still counted
    set_win(16'd0, 16'd0, 16'd0, 16'd8);
    mark();
    send_frame(16, 8, -1, 0);
    checks++; if (dval_cnt - mark_cnt != 0) begin errors++; $display("FAIL w0_dval: got %0d want 0", dval_cnt - mark_cnt); end
    checks++; if (eof_cnt - eof_m != 1 || bus.oFrame_Cont !== 32'd6) begin errors++; $display("FAIL w0_eof: got eof=%0d frame=%0d want 1/6", eof_cnt - eof_m, bus.oFrame_Cont); end
    // window end beyond 16 bits: only columns 65530..65535 exist in range
    set_win(16'd65530, 16'd0, 16'd100, 16'd1);
    mark();
    send_frame(65536, 1, -1, 0);
    checks++; if (dval_cnt - mark_cnt != 6) begin errors++; $display("FAIL wide_dval: got %0d want 6", dval_cnt - mark_cnt); end
    checks++; if (first_d !== pix(65530, 0) || last_x !== 16'd5) begin errors++; $display("FAIL wide_px: got d=%0d lastx=%0d want d=%0d lastx=5", first_d, last_x, pix(65530, 0)); end
    checks++; if (bus.oFrame_Cont !== 32'd7) begin errors++; $display("FAIL wide_frame: got %0d want 7", bus.oFrame_Cont); end
    // stop between frames, then iSTART and iEND together in IDLE
    @(negedge iCLK); bus.iEND = 1'b1;
    @(negedge iCLK); bus.iSTART = 1'b1;
    repeat (3) @(negedge iCLK);
    checks++; if (bus.oBUSY !== 1'b0) begin errors++; $display("FAIL startend_busy: got %0d want 0", bus.oBUSY); end
    bus.iSTART = 1'b0; bus.iEND = 1'b0;
    set_win(16'd0, 16'd0, 16'd8, 16'd2);
    mark();
    send_frame(8, 2, -1, 0);
    checks++; if (sof_cnt - sof_m != 0 || dval_cnt - mark_cnt != 0) begin errors++; $display("FAIL startend_idle: got sof=%0d dval=%0d want 0/0", sof_cnt - sof_m, dval_cnt - mark_cnt); end
  endtask

  // async reset mid-line, release with FVAL high and iSTART held
  task automatic test_async_reset();
    set_win(16'd0, 16'd0, 16'd8, 16'd4);
    @(negedge iCLK); bus.iSTART = 1'b1;
    drive_px(1'b1, 1'b0, 12'd0);
    drive_px(1'b1, 1'b0, 12'd0);
    for (int c = 0; c < 8; c++) drive_px(1'b1, 1'b1, pix(c, 0));
    for (int g = 0; g < 3; g++) drive_px(1'b1, 1'b0, 12'd0);
    for (int c = 0; c < 6; c++) drive_px(1'b1, 1'b1, pix(c, 1));
    @(posedge iCLK); #1;
    checks++; if (bus.oDVAL !== 1'b1) begin errors++; $display("FAIL ar_pre_dval: got %0d want 1", bus.oDVAL); end
    #1 iRST_N = 1'b0;
    #1;
    checks++; if (bus.oDVAL !== 1'b0 || bus.oBUSY !== 1'b0) begin errors++; $display("FAIL ar_async: got dval=%0d busy=%0d want 0/0", bus.oDVAL, bus.oBUSY); end
    checks++; if (bus.oFrame_Cont !== 32'd0) begin errors++; $display("FAIL ar_frame: got %0d want 0", bus.oFrame_Cont); end
    @(negedge iCLK); iRST_N = 1'b1;
    mark();
    for (int c = 6; c < 8; c++) drive_px(1'b1, 1'b1, pix(c, 1));
    for (int r = 2; r < 4; r++) begin
      for (int g = 0; g < 3; g++) drive_px(1'b1, 1'b0, 12'd0);
      for (int c = 0; c < 8; c++) drive_px(1'b1, 1'b1, pix(c, r));
    end
    for (int g = 0; g < 4; g++) drive_px(1'b0, 1'b0, 12'd0);
    checks++; if (dval_cnt - mark_cnt != 0 || sof_cnt - sof_m != 0 || eof_cnt - eof_m != 0) begin errors++; $display("FAIL ar_inflight: got dval=%0d sof=%0d eof=%0d want 0/0/0", dval_cnt - mark_cnt, sof_cnt - sof_m, eof_cnt - eof_m); end
    mark();
    send_frame(8, 4, -1, 0);
    bus.iSTART = 1'b0;
    checks++; if (dval_cnt - mark_cnt != 32 || sof_cnt - sof_m != 1) begin errors++; $display("FAIL ar_next: got dval=%0d sof=%0d want 32/1", dval_cnt - mark_cnt, sof_cnt - sof_m); end
    checks++; if (bus.oFrame_Cont !== 32'd1) begin errors++; $display("FAIL ar_next_frame: got %0d want 1", bus.oFrame_Cont); end
  endtask

  initial begin
    test_reset();
    test_full();
    test_crop();
    test_stop();
    test_roi_change();
    test_corners();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
